// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and helpers for the banked memory slice.
//   DATA_W_DEF / ADDR_W_DEF / NUM_PORTS_DEF / NUM_BANKS_DEF : default widths
//   log2c(n) : ceiling log2, used for the bank-select and pointer widths
package mem_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned NUM_PORTS_DEF = 4;
  localparam int unsigned NUM_BANKS_DEF = 4;

  function automatic int unsigned log2c(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_banked_rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one bank.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : N request lines (already masked by bank match)
//   grant    : one-hot grant (or zero), combinational
// The pointer moves to (winner+1) mod N only when something is granted.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned N = NUM_PORTS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (log2c(N) > 0) ? log2c(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Pass 0 scans ports at or above the pointer, pass 1 wraps to the ports
  // below it; the first requester found wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    ptr_d = ptr_q;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && ((pass == 0) == (i >= 32'(ptr_q)))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          ptr_d    = PTR_W'((i + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_banked.sv
// mem_banked: multi-port banked word memory with per-bank round-robin
// arbitration, one access per bank per cycle, read latency 1.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-port request present
//   req_ready   : per-port grant this cycle (combinational, low in reset)
//   req_we      : per-port 1 = write, 0 = read
//   req_addr    : packed per-port word address (low bits select the bank)
//   req_wdata   : packed per-port write data
//   resp_valid  : per-port read data valid, one cycle after acceptance
//   resp_data   : packed per-port read data, held when resp_valid is low
//   conflict_cnt: (only with MEM_BANKED_STATS_EN) saturating count of
//                 valid-but-not-granted requests
module mem_banked
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] resp_data
`ifdef MEM_BANKED_STATS_EN
  ,
  output logic [31:0]                 conflict_cnt
`endif
);

  localparam int unsigned BANK_W = log2c(NUM_BANKS);
  localparam int unsigned ROW_W  = ADDR_W - BANK_W;
  localparam int unsigned ROWS   = 1 << ROW_W;

  logic [BANK_W-1:0] port_bank [NUM_PORTS];
  logic [ROW_W-1:0]  port_row  [NUM_PORTS];

  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_req;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_gnt;

  logic [NUM_BANKS-1:0] bank_we;
  logic [ROW_W-1:0]     bank_wrow  [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];

  logic [DATA_W-1:0] mem [NUM_BANKS][ROWS];

  logic [NUM_PORTS-1:0]        resp_valid_q, resp_valid_d;
  logic [NUM_PORTS*DATA_W-1:0] resp_data_q,  resp_data_d;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = req_addr[p*ADDR_W +: BANK_W];
      port_row[p]  = req_addr[p*ADDR_W + BANK_W +: ROW_W];
    end
  end

  // Requests are masked during reset so nothing can be accepted then.
  always_comb begin
    bank_req = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = req_valid[p] && !rst && (32'(port_bank[p]) == b);
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (bank_req[gb]),
      .grant (bank_gnt[gb])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) req_ready = req_ready | bank_gnt[b];
  end

  always_comb begin
    bank_we = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_wrow[b]  = '0;
      bank_wdata[b] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p] && req_we[p]) begin
          bank_we[b]    = 1'b1;
          bank_wrow[b]  = port_row[p];
          bank_wdata[b] = req_wdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) mem[b][bank_wrow[b]] <= bank_wdata[b];
    end
  end

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req_ready[p] && !req_we[p]) begin
        resp_valid_d[p]                   = 1'b1;
        resp_data_d[p*DATA_W +: DATA_W]   = mem[port_bank[p]][port_row[p]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

`ifdef MEM_BANKED_STATS_EN
  logic [31:0] conflict_q, conflict_d;

  always_comb begin
    int unsigned lost;
    logic [32:0] sum;
    lost = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req_valid[p] && !req_ready[p]) lost++;
    end
    sum        = {1'b0, conflict_q} + 33'(lost);
    conflict_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_q <= '0;
    else     conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`else
  // No conflict statistics in this build.
`endif

endmodule

// File: doc/mem_banked.md
MEM_BANKED -- requirements
Module: mem_banked

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 16, word address width in bits.
REQ-003 Parameter NUM_PORTS, default 4, number of independent request ports (lanes).
REQ-004 Parameter NUM_BANKS, default 4, number of banks; power of two, 2..ADDR_W-bit range.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 req_valid  input  NUM_PORTS  per-port request present.
REQ-008 req_ready  output  NUM_PORTS  per-port request accepted this cycle (combinational grant).
REQ-009 req_we  input  NUM_PORTS  per-port 1 = write, 0 = read.
REQ-010 req_addr  input  NUM_PORTS*ADDR_W  per-port word address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-011 req_wdata  input  NUM_PORTS*DATA_W  per-port write data, packed as req_addr.
REQ-012 resp_valid  output  NUM_PORTS  per-port read data valid.
REQ-013 resp_data  output  NUM_PORTS*DATA_W  per-port read data, packed as req_addr.

Function
REQ-014 Bank select = req_addr[log2(NUM_BANKS)-1:0]; row = remaining upper bits; each bank holds 2^ADDR_W/NUM_BANKS words.
REQ-015 Each bank SHALL serve at most one request (read or write) per cycle.
REQ-016 Per-bank round-robin arbiter among ports with req_valid targeting that bank; req_ready[p] high iff port p wins its bank.
REQ-017 Arbiter pointer for a bank SHALL advance to (winner+1) mod NUM_PORTS only on a grant; no grant leaves it unchanged.
REQ-018 req_ready SHALL be low for any port with req_valid low.
REQ-019 Accepted write updates the bank row at the clock edge; no response generated.
REQ-020 Accepted read SHALL assert resp_valid[p] with data for exactly one cycle, exactly one cycle after acceptance (latency 1).
REQ-021 Read of a row written in an earlier cycle SHALL return the new data; same-cycle same-address conflicts are impossible by REQ-015.
REQ-022 Non-granted requests are stalled; requester holds valid/we/addr/wdata until ready; block stores no pending requests.
REQ-023 resp_data[p] SHALL hold its last value when resp_valid[p] is low.
REQ-024 All ports on distinct banks SHALL all be granted in the same cycle (full throughput).

Reset
REQ-025 rst high SHALL immediately clear resp_valid, resp_data and all arbiter pointers to 0.
REQ-026 Memory contents are not reset; a read accepted the cycle rst asserts SHALL produce no response.
REQ-027 req_ready SHALL be low while rst is high.

Configuration
REQ-028 Macro MEM_BANKED_STATS_EN: when defined, add output conflict_cnt (32 bits) counting, per cycle, the number of valid requests not granted; saturates at 2^32-1; cleared by rst.
REQ-029 Without MEM_BANKED_STATS_EN, conflict_cnt port and counter SHALL not exist; function otherwise identical.

Structure
REQ-030 Shared package mem_pkg SHALL hold default width constants and a log2 helper function for bank-select width.
REQ-031 Sub-module rr_arbiter (NUM_PORTS requests, grant vector, pointer register) instantiated once per bank.

Verification
REQ-032 Write 0x1234 to addr 0x0005 on port 0, next cycle read 0x0005 on port 2 -> resp_valid[2] one cycle later, resp_data 0x1234.
REQ-033 Ports 0-3 read addrs 0x10,0x11,0x12,0x13 same cycle -> req_ready=4'b1111, all four resp_valid next cycle.
REQ-034 Ports 0-3 all held valid reading addr 0x20 (bank 0) -> grants in order 0,1,2,3 over four cycles, one resp per cycle.
REQ-035 rst pulsed the cycle after a read is accepted -> resp_valid stays 0, pointers return to 0, later reads return pre-reset memory data.
REQ-036 With MEM_BANKED_STATS_EN, scenario REQ-034 -> conflict_cnt = 3+2+1 = 6 after four cycles; without macro the build has no conflict_cnt port.
